// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : div_ctrl
//  Purpose  : Sequencer for the iterative restoring divider in pipe3.
//             Captures operand magnitudes on a valid DIV/DIVU and produces
//             one quotient bit per cycle. It holds ready_to_go low until the
//             signed-corrected result is ready, then strobes the HI/LO write
//             when pipe3 is accepted downstream.
//  Ports    : clock, reset        - clock / synchronous active-high reset
//             valid, div_op       - pipe3 holds a valid DIV/DIVU instruction
//             unsigned_op         - 1 = DIVU, 0 = DIV
//             vsrc1, vsrc2        - dividend (rs), divisor (rt)
//             flush               - exception/eret cancel of pipe3
//             allow_out           - downstream accepts pipe3 this cycle
//             ready_to_go         - pipe3 may advance
//             busy, done          - iterating / result waiting for accept
//             hilo_we             - one-cycle HI/LO write strobe
//             quotient, remainder - results to LO / HI
//  Revision : 1.0 - initial release
// ============================================================================
module div_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             valid,
   input  logic             div_op,
   input  logic             unsigned_op,
   input  logic [WIDTH-1:0] vsrc1,
   input  logic [WIDTH-1:0] vsrc2,
   input  logic             flush,
   input  logic             allow_out,
   output logic             ready_to_go,
   output logic             busy,
   output logic             done,
   output logic             hilo_we,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int                 c_CNT_W = $clog2(WIDTH) + 1;
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // r_dvd starts as the dividend magnitude; each step shifts its MSB into
   // the partial remainder and the new quotient bit in at the LSB, so after
   // WIDTH steps it holds the unsigned quotient.
   logic [WIDTH-1:0]   r_dvd;
   logic [WIDTH-1:0]   r_dvs;
   logic [WIDTH-1:0]   r_prem;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_sign1;
   logic               r_sign2;
   logic               r_uns;
   logic               r_dvs_zero;

   logic               w_start;
   logic               w_last;
   logic               w_qbit;
   logic [WIDTH:0]     w_shift;
   logic [WIDTH:0]     w_diff;
   logic [WIDTH-1:0]   w_abs1;
   logic [WIDTH-1:0]   w_abs2;
   logic [WIDTH-1:0]   w_q_mag;
   logic [WIDTH-1:0]   w_r_mag;
   logic [WIDTH-1:0]   w_q_fix;
   logic [WIDTH-1:0]   w_r_fix;

   assign w_start = (r_state == S_IDLE) & valid & div_op & ~flush;
   assign w_last  = (r_cnt == c_LAST);

   assign w_abs1 = (~unsigned_op & vsrc1[WIDTH-1]) ? -vsrc1 : vsrc1;
   assign w_abs2 = (~unsigned_op & vsrc2[WIDTH-1]) ? -vsrc2 : vsrc2;

   // Trial subtraction is done at WIDTH+1 bits so the sign bit of w_diff
   // tells whether the divisor fits into the shifted partial remainder.
   assign w_shift = {r_prem, r_dvd[WIDTH-1]};
   assign w_diff  = w_shift - {1'b0, r_dvs};
   assign w_qbit  = ~w_diff[WIDTH];
   assign w_q_mag = {r_dvd[WIDTH-2:0], w_qbit};
   assign w_r_mag = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

   // With a zero divisor the remainder magnitude ends up as |dividend|, so
   // re-applying the dividend sign reproduces the captured vsrc1 exactly
   // (including the most negative value, which is its own negation).
   assign w_q_fix = r_dvs_zero ? {WIDTH{1'b1}} :
                    ((~r_uns & (r_sign1 ^ r_sign2)) ? -w_q_mag : w_q_mag);
   assign w_r_fix = (~r_uns & r_sign1) ? -w_r_mag : w_r_mag;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (w_start)   w_state_nxt = S_CALC;
            S_CALC:  if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (allow_out) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clock) begin
      if (reset) begin
         r_dvd      <= '0;
         r_dvs      <= '0;
         r_prem     <= '0;
         r_cnt      <= '0;
         r_sign1    <= 1'b0;
         r_sign2    <= 1'b0;
         r_uns      <= 1'b0;
         r_dvs_zero <= 1'b0;
         quotient   <= '0;
         remainder  <= '0;
      end else if (w_start) begin
         r_dvd      <= w_abs1;
         r_dvs      <= w_abs2;
         r_prem     <= '0;
         r_cnt      <= '0;
         r_sign1    <= vsrc1[WIDTH-1];
         r_sign2    <= vsrc2[WIDTH-1];
         r_uns      <= unsigned_op;
         r_dvs_zero <= (vsrc2 == '0);
      end else if ((r_state == S_CALC) && !flush) begin
         r_prem <= w_r_mag;
         r_dvd  <= w_q_mag;
         r_cnt  <= r_cnt + 1'b1;
         if (w_last) begin
            quotient  <= w_q_fix;
            remainder <= w_r_fix;
         end
      end
   end

   // ------------------------------------------------------------ outputs
   assign busy        = (r_state == S_CALC);
   assign done        = (r_state == S_DONE);
   assign hilo_we     = done & allow_out & ~flush;
   assign ready_to_go = ~(valid & div_op) | done;

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_div_ctrl
//  Purpose  : Self-checking bench for div_ctrl. Expected quotient/remainder
//             come from plain integer division in a reference function;
//             latency, stall, flush, hold and back-to-back behaviour are
//             checked per scenario task.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div_ctrl;
   localparam int WIDTH = 32;

   logic             clock = 1'b0;
   logic             reset;
   logic             valid;
   logic             div_op;
   logic             unsigned_op;
   logic [WIDTH-1:0] vsrc1;
   logic [WIDTH-1:0] vsrc2;
   logic             flush;
   logic             allow_out;
   logic             ready_to_go;
   logic             busy;
   logic             done;
   logic             hilo_we;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;

   int               n_checks   = 0;
   int               n_fail     = 0;
   int               n_pulses   = 0;
   int               exp_pulses = 0;
   logic [WIDTH-1:0] last_q     = '0;
   logic [WIDTH-1:0] last_r     = '0;

   div_ctrl #(.WIDTH(WIDTH)) dut (
      .clock       (clock),
      .reset       (reset),
      .valid       (valid),
      .div_op      (div_op),
      .unsigned_op (unsigned_op),
      .vsrc1       (vsrc1),
      .vsrc2       (vsrc2),
      .flush       (flush),
      .allow_out   (allow_out),
      .ready_to_go (ready_to_go),
      .busy        (busy),
      .done        (done),
      .hilo_we     (hilo_we),
      .quotient    (quotient),
      .remainder   (remainder)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (hilo_we === 1'b1) n_pulses++;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Reference: MIPS-style truncating division, modulo 2^WIDTH results.
   function automatic void ref_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic uns,
                                   output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r);
      longint sa;
      longint sb;
      if (b == '0) begin
         q = '1;
         r = a;
      end else if (uns) begin
         q = a / b;
         r = a % b;
      end else begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = WIDTH'(sa / sb);
         r  = WIDTH'(sa % sb);
      end
   endfunction

   task automatic go_idle();
      valid     = 1'b0;
      div_op    = 1'b0;
      allow_out = 1'b0;
      flush     = 1'b0;
      tick();
   endtask

   // Issues a divide in the current cycle, checks the stall window, latency,
   // result, an optional number of DONE cycles with allow_out low, and the
   // accept. Leaves valid asserted so a caller can chain a back-to-back op.
   task automatic run_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic uns, input int hold, input string tag);
      logic [WIDTH-1:0] eq;
      logic [WIDTH-1:0] er;
      int               n;
      logic             stall_ok;
      ref_div(a, b, uns, eq, er);
      valid = 1'b1; div_op = 1'b1; unsigned_op = uns;
      vsrc1 = a; vsrc2 = b; allow_out = 1'b0; flush = 1'b0;
      #1;
      n_checks++;
      if (ready_to_go !== 1'b0) begin
         n_fail++;
         $display("FAIL %s start_stall: ready_to_go=%b expected 0", tag, ready_to_go);
      end
      n = 0;
      stall_ok = 1'b1;
      while (n < 100) begin
         tick();
         n++;
         vsrc1 = $urandom; vsrc2 = $urandom; unsigned_op = 1'($urandom_range(0, 1));
         #1;
         if (done === 1'b1) break;
         if (ready_to_go !== 1'b0 || busy !== 1'b1) stall_ok = 1'b0;
      end
      n_checks++;
      if (n != WIDTH + 1) begin
         n_fail++;
         $display("FAIL %s latency: got %0d cycles expected %0d", tag, n, WIDTH + 1);
      end
      n_checks++;
      if (stall_ok !== 1'b1) begin
         n_fail++;
         $display("FAIL %s calc_stall: busy/ready_to_go wrong during CALC (got %b expected 1)", tag, stall_ok);
      end
      n_checks++;
      if (quotient !== eq || remainder !== er) begin
         n_fail++;
         $display("FAIL %s result: q=%h r=%h expected q=%h r=%h", tag, quotient, remainder, eq, er);
      end
      for (int k = 0; k < hold; k++) begin
         tick();
         #1;
         n_checks++;
         if ({done, hilo_we, ready_to_go, quotient, remainder} !== {1'b1, 1'b0, 1'b1, eq, er}) begin
            n_fail++;
            $display("FAIL %s hold%0d: done=%b we=%b rtg=%b q=%h r=%h expected 1 0 1 q=%h r=%h",
                     tag, k, done, hilo_we, ready_to_go, quotient, remainder, eq, er);
         end
      end
      allow_out = 1'b1;
      #1;
      n_checks++;
      if ({hilo_we, ready_to_go} !== 2'b11) begin
         n_fail++;
         $display("FAIL %s accept: hilo_we=%b ready_to_go=%b expected 1 1", tag, hilo_we, ready_to_go);
      end
      exp_pulses++;
      tick();
      allow_out = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, hilo_we} !== 3'b000) begin
         n_fail++;
         $display("FAIL %s after_accept: busy=%b done=%b we=%b expected 0 0 0", tag, busy, done, hilo_we);
      end
      last_q = eq;
      last_r = er;
   endtask

   task automatic test_reset();
      reset = 1'b1; valid = 1'b0; div_op = 1'b0; unsigned_op = 1'b0;
      vsrc1 = '0; vsrc2 = '0; flush = 1'b0; allow_out = 1'b0;
      tick(); tick(); tick();
      n_checks++;
      if ({busy, done, hilo_we, ready_to_go, quotient, remainder} !== {4'b0001, {2*WIDTH{1'b0}}}) begin
         n_fail++;
         $display("FAIL reset_state: busy=%b done=%b we=%b rtg=%b q=%h r=%h expected 0 0 0 1 0 0",
                  busy, done, hilo_we, ready_to_go, quotient, remainder);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_directed();
      run_div(32'd100, 32'd7, 1'b1, 0, "divu_100_7");             go_idle();
      run_div(-32'sd7, 32'd2, 1'b0, 0, "div_m7_2");               go_idle();
      run_div(32'd7, -32'sd2, 1'b0, 0, "div_7_m2");               go_idle();
      run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, "div_ovf");  go_idle();
      run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "divu_big"); go_idle();
      run_div(32'd5, 32'd0, 1'b0, 0, "div_by_zero");              go_idle();
      run_div(-32'sd9, 32'd0, 1'b0, 0, "div_neg_by_zero");        go_idle();
   endtask

   task automatic test_nondiv();
      valid = 1'b1; div_op = 1'b0; vsrc1 = 32'd50; vsrc2 = 32'd5;
      #1;
      n_checks++;
      if (ready_to_go !== 1'b1) begin
         n_fail++;
         $display("FAIL nondiv_rtg: ready_to_go=%b expected 1", ready_to_go);
      end
      tick();
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL nondiv_nostart: busy=%b expected 0", busy);
      end
      go_idle();
   endtask

   task automatic test_flush();
      logic [WIDTH-1:0] pq;
      logic [WIDTH-1:0] pr;
      logic [WIDTH-1:0] eq;
      logic [WIDTH-1:0] er;
      int               n;
      pq = last_q; pr = last_r;
      // flush mid-CALC at cycle 10
      valid = 1'b1; div_op = 1'b1; unsigned_op = 1'b1; vsrc1 = 32'd1000; vsrc2 = 32'd3;
      for (int k = 0; k < 10; k++) tick();
      flush = 1'b1;
      #1;
      n_checks++;
      if ({busy, hilo_we} !== 2'b10) begin
         n_fail++;
         $display("FAIL flush_calc: busy=%b we=%b expected 1 0", busy, hilo_we);
      end
      tick();
      flush = 1'b0; valid = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, quotient, remainder} !== {2'b00, pq, pr}) begin
         n_fail++;
         $display("FAIL flush_idle: busy=%b done=%b q=%h r=%h expected 0 0 q=%h r=%h",
                  busy, done, quotient, remainder, pq, pr);
      end
      tick();
      run_div(32'd9, 32'd3, 1'b1, 0, "divu_9_3_after_flush");
      go_idle();
      // flush in IDLE suppresses start
      valid = 1'b1; div_op = 1'b1; flush = 1'b1;
      tick();
      flush = 1'b0; valid = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_nostart: busy=%b expected 0", busy);
      end
      tick();
      // flush while in DONE with allow_out high: no write, results kept
      ref_div(32'd77, 32'd10, 1'b1, eq, er);
      valid = 1'b1; div_op = 1'b1; unsigned_op = 1'b1; vsrc1 = 32'd77; vsrc2 = 32'd10;
      n = 0;
      while (n < 100) begin
         tick();
         n++;
         if (done === 1'b1) break;
      end
      flush = 1'b1; allow_out = 1'b1;
      #1;
      n_checks++;
      if ({done, hilo_we} !== 2'b10) begin
         n_fail++;
         $display("FAIL flush_done_we: done=%b we=%b after %0d cycles expected 1 0", done, hilo_we, n);
      end
      tick();
      flush = 1'b0; allow_out = 1'b0; valid = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, quotient, remainder} !== {2'b00, eq, er}) begin
         n_fail++;
         $display("FAIL flush_done_idle: busy=%b done=%b q=%h r=%h expected 0 0 q=%h r=%h",
                  busy, done, quotient, remainder, eq, er);
      end
      last_q = eq; last_r = er;
      tick();
   endtask

   task automatic test_hold();
      run_div(32'hFFFF_FF00, 32'd13, 1'b0, 5, "hold_signed");
      go_idle();
   endtask

   task automatic test_back_to_back();
      run_div(32'd1234567, 32'd89, 1'b1, 0, "b2b_first");
      run_div(-32'sd1000, 32'd33, 1'b0, 2, "b2b_second");
      run_div(32'd3, 32'd0, 1'b1, 0, "b2b_third");
      go_idle();
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             uns;
      for (int i = 0; i < 10; i++) begin
         a   = ($urandom_range(0, 1) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 5000));
         case ($urandom_range(0, 3))
            0:       b = '0;
            1:       b = WIDTH'($urandom_range(1, 20));
            2:       b = -WIDTH'($urandom_range(1, 20));
            default: b = WIDTH'($urandom);
         endcase
         uns = 1'($urandom_range(0, 1));
         run_div(a, b, uns, int'($urandom_range(0, 2)), $sformatf("rand%0d", i));
         if ($urandom_range(0, 1) == 0) go_idle();
      end
      go_idle();
   endtask

   task automatic test_reset_mid();
      valid = 1'b1; div_op = 1'b1; unsigned_op = 1'b0; vsrc1 = 32'd999; vsrc2 = 32'd7;
      for (int k = 0; k < 15; k++) tick();
      reset = 1'b1;
      tick();
      n_checks++;
      if ({busy, done, hilo_we, quotient, remainder} !== {3'b000, {2*WIDTH{1'b0}}}) begin
         n_fail++;
         $display("FAIL reset_mid: busy=%b done=%b we=%b q=%h r=%h expected all 0",
                  busy, done, hilo_we, quotient, remainder);
      end
      reset = 1'b0;
      go_idle();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_nondiv();
      test_flush();
      test_hold();
      test_back_to_back();
      test_random();
      test_reset_mid();
      tick();
      tick();
      n_checks++;
      if (n_pulses != exp_pulses) begin
         n_fail++;
         $display("FAIL hilo_pulse_count: got %0d expected %0d", n_pulses, exp_pulses);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
